// File: rtl/clk_gen_pkg.sv
// Shared definitions for the ring-oscillator clock generator blocks.
//   state_e            : frequency meter FSM states
//   WINDOW_WIDTH_DEF   : default width of the measurement window length
//   COUNT_WIDTH_DEF    : default width of the edge counter
package clk_gen_pkg;

    localparam int unsigned WINDOW_WIDTH_DEF = 16;
    localparam int unsigned COUNT_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/clk_gen_sync_edge.sv
// Two-flop synchronizer followed by an edge flop, producing a one-cycle
// rising-edge pulse for an asynchronous input.
//   clk_i     : sampling clock
//   reset_n_i : asynchronous active-low reset, clears all three flops
//   d_i       : asynchronous input
//   rise_o    : high for one clk_i cycle per rising edge seen on d_i,
//               3 cycles after the edge (s2 & ~s3)
module clk_gen_sync_edge (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic rise_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = d_i;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // Decoded from flops only, so the pulse is glitch-free for the counter.
    assign rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/clk_gen_freq_meter.sv
// Frequency meter: counts rising edges of osc_i over a window of N clk_i
// cycles and returns the count through a valid/yumi handshake.
//   clk_i, reset_n_i : reference clock, asynchronous active-low reset
//   osc_i            : oscillator output, asynchronous to clk_i
//   start_v_i        : measurement request, accepted when ready_o is high
//   window_i         : window length N, sampled on acceptance
//   ready_o          : idle, able to accept start_v_i
//   result_v_o       : result_count_o / result_ovf_o are valid
//   result_count_o   : saturating edge count
//   result_ovf_o     : sticky saturation flag
//   result_yumi_i    : consumer takes the result
//   dbg_state_o      : current FSM state (clk_gen_pkg::state_e encoding)
//
// Handshake: a request transfers on a clock edge where start_v_i && ready_o;
// a result transfers on a clock edge where result_v_o && result_yumi_i.
// ready_o and result_v_o are never high together, so a new request can
// never be accepted on the same edge that a result is consumed.
module clk_gen_freq_meter
    import clk_gen_pkg::*;
#(
    parameter int unsigned window_width_p = WINDOW_WIDTH_DEF,
    parameter int unsigned count_width_p  = COUNT_WIDTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      osc_i,
    input  logic                      start_v_i,
    input  logic [window_width_p-1:0] window_i,
    output logic                      ready_o,
    output logic                      result_v_o,
    output logic [count_width_p-1:0]  result_count_o,
    output logic                      result_ovf_o,
    input  logic                      result_yumi_i,
    output logic [1:0]                dbg_state_o
);

    state_e                    state_q, state_d;
    logic [window_width_p-1:0] win_q, win_d;
    logic [count_width_p-1:0]  cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic                      ready_q, ready_d;
    logic                      valid_q, valid_d;
    logic                      osc_rise;

    clk_gen_sync_edge u_sync_edge (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d_i       (osc_i),
        .rise_o    (osc_rise)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ready_d = ready_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (start_v_i) begin
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    ready_d = 1'b0;
                    win_d   = window_i;
                    // A zero window skips counting; valid is raised from
                    // DONE one cycle later, giving a latency of 1.
                    if (window_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_MEASURE;
                    end
                end
            end
            ST_MEASURE: begin
                win_d = win_q - window_width_p'(1);
                if (osc_rise) begin
                    if (cnt_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + count_width_p'(1);
                    end
                end
                // Last window cycle: its edge pulse is still counted above.
                if (win_q == window_width_p'(1)) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                valid_d = 1'b1;
                // yumi is only meaningful once the result is visible.
                if (result_yumi_i && valid_q) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign ready_o        = ready_q;
    assign result_v_o     = valid_q;
    assign result_count_o = cnt_q;
    assign result_ovf_o   = ovf_q;
    assign dbg_state_o    = state_q;

endmodule

// File: doc/clk_gen_freq_meter.md
# clk_gen_freq_meter

Frequency meter for the on-chip ring-oscillator clock generator. It counts rising edges of the oscillator output, or of its downsampled output, over a programmable window of reference-clock cycles, then returns the edge count through a valid/yumi handshake. Software and the test controller use the count to calibrate oscillator trim settings. The oscillator signal is asynchronous data to this block; there is only one clock domain.

## Interface
- window_width_p, default 16: width of the measurement window length, in reference cycles.
- count_width_p, default 16: width of the edge counter.

- clk_i, input, 1: reference clock; the only clock.
- reset_n_i, input, 1: reset, asynchronous, active-low.
- osc_i, input, 1: oscillator output, asynchronous to clk_i. Its frequency must be below clk_i/2 for exact counts.
- start_v_i, input, 1: measurement request.
- window_i, input, window_width_p: window length N in clk_i cycles. Sampled on acceptance.
- ready_o, output, 1: block is idle and can accept start_v_i.
- result_v_o, output, 1: result is valid.
- result_count_o, output, count_width_p: number of rising edges counted in the window.
- result_ovf_o, output, 1: the edge counter saturated.
- result_yumi_i, input, 1: consumer takes the result. Legal only while result_v_o is high.

## Operation
- osc_i passes through a 2-flop synchronizer, then an edge flop. Rising-edge pulse is s2 & ~s3. All three flops reset to 0.
- The FSM has three states: IDLE, MEASURE, DONE. Reset enters IDLE.
- IDLE:
  - ready_o = 1.
  - start_v_i = 1 accepts the request and latches N = window_i.
  - If N = 0, go to DONE with count 0 and ovf 0.
  - Otherwise go to MEASURE with the window counter = N, the edge counter = 0 and ovf = 0.
- MEASURE:
  - Every cycle the window counter decrements.
  - Every cycle with an edge pulse, the edge counter increments.
  - At all-ones the edge counter holds and ovf is set sticky.
  - When the window counter goes from 1 to 0, go to DONE. An edge pulse in that same cycle is counted.
- DONE:
  - result_v_o = 1. result_count_o and result_ovf_o are stable.
  - result_yumi_i = 1 returns to IDLE.
  - A new start cannot be accepted in the same cycle as yumi, because ready_o is 0 in DONE.
- start_v_i outside IDLE is ignored and not queued.
- result_yumi_i outside DONE is ignored.
- The synchronizer runs continuously in every state. Edges outside MEASURE are never counted.
- Reset asserted mid-operation clears every register immediately. Any in-flight measurement is discarded with no result.

## Timing
- Reset values: ready_o = 1, result_v_o = 0, result_count_o = 0, result_ovf_o = 0.
- Acceptance takes place at clock edge T0 when start_v_i and ready_o are both high.
- MEASURE covers cycles T0+1 through T0+N, which is exactly N cycles.
- result_v_o rises after edge T0+N, so the result latency is N cycles.
- For N = 0, result_v_o rises after T0+1.
- Synchronizer latency is 3 cycles from osc_i to the edge pulse. The window is therefore shifted 3 cycles late relative to osc_i; this is accepted, not compensated.
- The result registers change only on entry to MEASURE (clear) and during MEASURE (update). They are otherwise held, including across arbitrarily long backpressure in DONE.
- Every output is registered. No combinational path exists from inputs to outputs.

## Structure
- Shared package clk_gen_pkg holds the FSM state enum (IDLE, MEASURE, DONE) and the default width constants.
- One sub-module, clk_gen_sync_edge: 2-flop synchronizer plus rising-edge detector. It is reusable by the downsampler control path.
- The FSM, the counters and the result registers live in the top module.

## Test plan
- Reset check: drive reset_n_i low mid-clock. Outputs must go to their reset values without waiting for a clock edge. After release, ready_o = 1 and result_v_o = 0.
- Toggle test: osc_i toggles every clk_i cycle (period 2), N = 20 → result_count_o = 10, result_ovf_o = 0, result_v_o rising exactly 20 cycles after acceptance.
- Static input: osc_i held high (then held low), N = 100 → count 0 in both cases. N = 0 → count 0 and result_v_o one cycle after acceptance.
- Saturation: count_width_p = 4, osc_i period 2, N = 40 → count 15, ovf 1. A following run with N = 10 → count 5, ovf 0, showing ovf cleared.
- Backpressure: hold result_yumi_i low for 50 cycles and pulse start_v_i during that time. The result must stay stable, ready_o must stay 0, and no new measurement may start. After yumi, ready_o = 1 on the next cycle.
- Reset mid-measure: assert reset_n_i during MEASURE with N = 100. After release: IDLE, no result_v_o. A fresh N = 20 toggle run → count 10.
